// File: rtl/calib_sched_pkg.sv
// Shared types and constants for the calibration-engine scheduler.
// Imported by the scheduler top and its round-robin arbiter.
package calib_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   localparam logic [4:0] POS_INVALID = 5'h1F;

   // Bits needed to index n items; never less than one.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/calib_scheduler_if.sv
// Channel-side and engine-side signal bundle of the calibration scheduler.
// The scheduler uses the slave view; the channels/engine environment uses master.
interface calib_scheduler_if #(
   parameter int M    = 16,
   parameter int N    = 16,
   parameter int NREQ = 4
) ();

   logic [NREQ-1:0]   req;
   logic [NREQ*M-1:0] req_x;
   logic [NREQ-1:0]   done;
   logic [N-1:0]      resp_y;
   logic [4:0]        resp_pos;
   logic              resp_timeout;
   logic              busy;

   logic              eng_start;
   logic [M-1:0]      eng_x;
   logic              eng_ready;
   logic [N-1:0]      eng_y;
   logic [4:0]        eng_pos;

   modport slave (
      input  req, req_x, eng_ready, eng_y, eng_pos,
      output done, resp_y, resp_pos, resp_timeout, busy, eng_start, eng_x
   );

   modport master (
      output req, req_x, eng_ready, eng_y, eng_pos,
      input  done, resp_y, resp_pos, resp_timeout, busy, eng_start, eng_x
   );

endinterface

// File: rtl/calib_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr,
// searching upward modulo NREQ.
module rr_arbiter
   import calib_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = idx_width(NREQ)
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   rr_ptr_i,
   output logic [NREQ-1:0] grant_o,
   output logic [IW-1:0]   gidx_o,
   output logic            valid_o
);

   logic [IW-1:0]   cand_idx [NREQ];
   logic [NREQ-1:0] cand_hit;

   // Candidate gi is the channel sitting gi places after the pointer.
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_rot
         logic [IW:0] sum;
         assign sum          = {1'b0, rr_ptr_i} + (IW+1)'(gi);
         assign cand_idx[gi] = (sum >= (IW+1)'(NREQ)) ? IW'(sum - (IW+1)'(NREQ))
                                                       : sum[IW-1:0];
         assign cand_hit[gi] = req_i[cand_idx[gi]];
      end
   endgenerate

   always_comb begin
      gidx_o  = '0;
      valid_o = 1'b0;
      grant_o = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (cand_hit[k]) begin
            gidx_o  = cand_idx[k];
            valid_o = 1'b1;
         end
      end
      if (valid_o) begin
         grant_o[gidx_o] = 1'b1;
      end
   end

endmodule

// File: rtl/calib_scheduler.sv
// Shares one LUT calibration engine among NREQ phase channels: round-robin
// grant, engine start/wait with timeout, result returned with a done pulse.
module calib_scheduler
   import calib_sched_pkg::*;
#(
   parameter int M       = 16,
   parameter int N       = 16,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 32
) (
   input  logic               clock,
   input  logic               reset,
   calib_scheduler_if.slave   bus
);

   localparam int IW = idx_width(NREQ);
   localparam int TW = $clog2(TIMEOUT) + 1;

   state_e          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IW-1:0]   gidx_q, gidx_d;
   logic [M-1:0]    eng_x_q, eng_x_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [N-1:0]    resp_y_q, resp_y_d;
   logic [4:0]      resp_pos_q, resp_pos_d;
   logic            resp_timeout_q, resp_timeout_d;

   logic [NREQ-1:0] arb_grant;
   logic [IW-1:0]   arb_gidx;
   logic            arb_valid;
   logic [NREQ-1:0] done_s;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req_i    (bus.req),
      .rr_ptr_i (rr_ptr_q),
      .grant_o  (arb_grant),
      .gidx_o   (arb_gidx),
      .valid_o  (arb_valid)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         rr_ptr_q       <= '0;
         gidx_q         <= '0;
         eng_x_q        <= '0;
         timer_q        <= '0;
         resp_y_q       <= '0;
         resp_pos_q     <= '0;
         resp_timeout_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         rr_ptr_q       <= rr_ptr_d;
         gidx_q         <= gidx_d;
         eng_x_q        <= eng_x_d;
         timer_q        <= timer_d;
         resp_y_q       <= resp_y_d;
         resp_pos_q     <= resp_pos_d;
         resp_timeout_q <= resp_timeout_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      rr_ptr_d       = rr_ptr_q;
      gidx_d         = gidx_q;
      eng_x_d        = eng_x_q;
      timer_d        = timer_q;
      resp_y_d       = resp_y_q;
      resp_pos_d     = resp_pos_q;
      resp_timeout_d = resp_timeout_q;
      case (state_q)
         ST_IDLE: begin
            if (arb_valid) begin
               gidx_d  = arb_gidx;
               eng_x_d = bus.req_x[arb_gidx*M +: M];
               state_d = ST_START;
            end
         end
         ST_START: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (timer_q != '1) begin
               timer_d = timer_q + 1'b1;
            end
            // timer_q == 0 is the first WAIT cycle, where ready may be stale.
            if (timer_q != '0) begin
               if (bus.eng_ready) begin
                  resp_y_d       = bus.eng_y;
                  resp_pos_d     = bus.eng_pos;
                  resp_timeout_d = 1'b0;
                  state_d        = ST_RESP;
               end else if (timer_q >= TW'(TIMEOUT - 1)) begin
                  resp_y_d       = '0;
                  resp_pos_d     = POS_INVALID;
                  resp_timeout_d = 1'b1;
                  state_d        = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            rr_ptr_d = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      done_s = '0;
      if (state_q == ST_RESP) begin
         done_s[gidx_q] = 1'b1;
      end
   end

   assign bus.done         = done_s;
   assign bus.resp_y       = resp_y_q;
   assign bus.resp_pos     = resp_pos_q;
   assign bus.resp_timeout = resp_timeout_q;
   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.eng_start    = (state_q == ST_START);
   assign bus.eng_x        = eng_x_q;

endmodule

// File: tb/tb_calib_scheduler.sv
// Self-checking bench for calib_scheduler: directed scenarios plus random
// transactions checked against a cycle-count/round-robin reference model.
module tb_calib_scheduler;

   localparam int M       = 16;
   localparam int N       = 16;
   localparam int NREQ    = 4;
   localparam int TIMEOUT = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   calib_scheduler_if #(.M(M), .N(N), .NREQ(NREQ)) bus ();

   calib_scheduler #(
      .M       (M),
      .N       (N),
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int rr_model = 0;
   logic [M-1:0] x_arr [NREQ];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      assert (obs === exp_v)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] m, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (m[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return 0;
   endfunction

   // w: WAIT-cycle index (0-based) on which the engine raises ready; values
   // outside 1..TIMEOUT-1 mean the engine never answers in time.
   task automatic run_txn(input logic [NREQ-1:0] mask, input int w, input bit stale,
                          input bit keep_req, input bit drop_after_grant);
      int g, exp_done;
      bit tmo, rdy;
      logic [M-1:0] exp_x;
      logic [N-1:0] y_good, y_stale, exp_y;
      logic [4:0] p_good, p_stale, exp_pos;
      logic [NREQ-1:0] exp_dv;
      g        = pick(mask, rr_model);
      tmo      = !(w >= 1 && w <= TIMEOUT - 1);
      exp_done = tmo ? TIMEOUT + 2 : w + 3;
      exp_x    = x_arr[g];
      y_good   = N'($urandom);
      y_stale  = y_good ^ 16'h5A5A;
      p_good   = 5'($urandom_range(0, 30));
      p_stale  = p_good ^ 5'h0A;
      exp_y    = tmo ? '0 : y_good;
      exp_pos  = tmo ? 5'h1F : p_good;
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) bus.req_x[i*M +: M] = x_arr[i];
      bus.req       = mask;
      bus.eng_ready = 1'b0;
      bus.eng_y     = y_stale;
      bus.eng_pos   = p_stale;
      for (int n = 1; n <= exp_done; n++) begin
         @(posedge clk);
         #1;
         exp_dv = (n == exp_done) ? (NREQ'(1) << g) : '0;
         chk("eng_start", bus.eng_start, (n == 1));
         chk("busy", bus.busy, 1'b1);
         chk("eng_x", bus.eng_x, exp_x);
         chk("done", bus.done, exp_dv);
         if (n == exp_done) begin
            chk("resp_y", bus.resp_y, exp_y);
            chk("resp_pos", bus.resp_pos, exp_pos);
            chk("resp_timeout", bus.resp_timeout, tmo);
            rr_model = (g + 1) % NREQ;
            if (!keep_req) bus.req = '0;
         end
         if (n == 1 && drop_after_grant) begin
            bus.req[g]          = 1'b0;
            bus.req_x[g*M +: M] = ~exp_x;
         end
         rdy           = (n == 1) ? stale : ((n - 2 == w) || (stale && n == 2));
         bus.eng_ready = rdy;
         bus.eng_y     = (rdy && n - 2 == w) ? y_good : y_stale;
         bus.eng_pos   = (rdy && n - 2 == w) ? p_good : p_stale;
      end
      @(posedge clk);
      #1;
      bus.eng_ready = 1'b0;
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_done", bus.done, '0);
      chk("resp_hold", bus.resp_y, exp_y);
      $display("txn mask=%b ch=%0d x=%0d w=%0d timeout=%0b y=%0d pos=%0d",
               mask, g, $signed(exp_x), w, tmo, $signed(exp_y), exp_pos);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req       = '0;
      bus.req_x     = '0;
      bus.eng_ready = 1'b0;
      bus.eng_y     = '0;
      bus.eng_pos   = '0;
      for (int i = 0; i < NREQ; i++) x_arr[i] = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_done", bus.done, '0);
      chk("rst_start", bus.eng_start, 1'b0);
      chk("rst_eng_x", bus.eng_x, '0);
      chk("rst_resp_y", bus.resp_y, '0);
      chk("rst_resp_pos", bus.resp_pos, '0);
      chk("rst_timeout", bus.resp_timeout, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // No request: stays idle
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("noreq_busy", bus.busy, 1'b0);
      end

      // Single request on channel 1, ready on 2nd WAIT cycle
      x_arr[1] = 16'sd1200;
      run_txn(4'b0010, 1, 1'b0, 1'b0, 1'b0);

      // Round robin with all channels continuously requesting
      x_arr[0] = 16'sd111;  x_arr[1] = -16'sd222;
      x_arr[2] = 16'sd333;  x_arr[3] = -16'sd444;
      rr_model = 2;
      // rr pointer is 2 after serving channel 1; bring it round to 0 first
      run_txn(4'b1111, 2, 1'b0, 1'b1, 1'b0);
      run_txn(4'b1111, 1, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) run_txn(4'b1111, 1 + k, 1'b0, 1'b1, 1'b0);
      bus.req = '0;

      // Timeout: engine never answers
      x_arr[0] = 16'sd77;
      run_txn(4'b0001, TIMEOUT + 5, 1'b0, 1'b0, 1'b0);

      // Stale ready in START and first WAIT, real answer on 5th WAIT cycle
      x_arr[3] = -16'sd9;
      run_txn(4'b1000, 4, 1'b1, 1'b0, 1'b0);

      // Serve channel 0 then 1 so the pointer sits at 2 before the reset
      run_txn(4'b0001, 1, 1'b0, 1'b0, 1'b0);
      run_txn(4'b0010, 1, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of WAIT
      @(negedge clk);
      x_arr[2] = 16'sd5;
      bus.req_x[2*M +: M] = x_arr[2];
      bus.req = 4'b0100;
      repeat (3) begin
         @(posedge clk);
         #1;
         chk("prerst_done", bus.done, '0);
      end
      @(negedge clk);
      rst = 1'b1;
      bus.req = '0;
      @(posedge clk);
      #1;
      chk("midrst_busy", bus.busy, 1'b0);
      chk("midrst_done", bus.done, '0);
      chk("midrst_eng_x", bus.eng_x, '0);
      @(negedge clk);
      rst = 1'b0;
      rr_model = 0;
      @(posedge clk);
      #1;
      chk("postrst_done", bus.done, '0);
      run_txn(4'b1001, 2, 1'b0, 1'b0, 1'b0);
      run_txn(4'b1000, 3, 1'b0, 1'b0, 1'b0);

      // Drop and re-request: pointer at 1 with ch0 pending, ch2 wins
      run_txn(4'b0001, 1, 1'b0, 1'b0, 1'b0);
      x_arr[0] = 16'sd1000;
      x_arr[2] = -16'sd2000;
      run_txn(4'b0101, 3, 1'b0, 1'b1, 1'b1);
      run_txn(4'b0001, 2, 1'b0, 1'b0, 1'b0);

      // Randomized transactions
      for (int t = 0; t < 16; t++) begin
         int w;
         for (int i = 0; i < NREQ; i++) x_arr[i] = M'($urandom);
         w = ($urandom_range(0, 3) == 0) ? TIMEOUT + $urandom_range(0, 3)
                                          : $urandom_range(1, TIMEOUT - 1);
         run_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), w,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/calib_scheduler.md
Name: calib_scheduler

Overview:
Sequences the shared phase-calibration lookup engine: the LUT binary-search block with start/ready, X in, Y/pos out. Up to NREQ phase channels issue lookup requests. The block picks one request round-robin, launches the engine, and watches for completion with a timeout. It then returns Y/pos to the granted channel with a one-cycle done pulse. It sits between the per-channel phase front-ends and the single calibration engine instance.

Parameters:
M, 16, width of lookup input X (signed)
N, 16, width of lookup result Y (signed)
NREQ, 4, number of requesting channels (2..8)
TIMEOUT, 32, max WAIT cycles before a lookup is abandoned (>=4)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req  in  NREQ  per-channel request level
req_x  in  NREQ*M  per-channel X; channel i occupies bits [i*M +: M]
done  out  NREQ  one-hot, one-cycle completion pulse to the served channel
resp_y  out  N  signed result; valid when any done bit is set, held until the next completion
resp_pos  out  5  LUT position of the result; 5'h1F on timeout
resp_timeout  out  1  set with done when the engine did not answer
busy  out  1  high in every state except IDLE
eng_start  out  1  one-cycle start pulse to the engine
eng_x  out  M  X presented to the engine; stable from START through RESP
eng_ready  in  1  engine completion flag
eng_y  in  N  engine result
eng_pos  in  5  engine position

Behaviour:
- Reset (synchronous, active-high): state=IDLE, rr_ptr=0, and done, resp_y, resp_pos, resp_timeout, busy, eng_start, eng_x all 0. Reset in any state aborts the lookup; no done pulse is issued for it.
- IDLE: if req is nonzero, the grant goes to the first asserted req at or after rr_ptr, searching upward mod NREQ. Latch that index as gidx and latch req_x[gidx] into eng_x, then go to START. If req is zero, stay in IDLE.
- START: eng_start=1 for exactly this cycle. Clear the timer. Go to WAIT.
- WAIT: eng_start=0. The timer increments each cycle. eng_ready is ignored in the first WAIT cycle, because of the engine's stale ready after start. From the second WAIT cycle on:
  - If eng_ready=1: capture eng_y and eng_pos, set resp_timeout=0, go to RESP.
  - Else if the timer reaches TIMEOUT-1: set resp_y=0, resp_pos=5'h1F, resp_timeout=1, go to RESP.
- RESP: done[gidx]=1 for this cycle only. Set rr_ptr=(gidx+1) mod NREQ. Go to IDLE. resp_* holds its value until the next RESP.
- Minimum service time is 5 cycles, from req sampled in IDLE to done: IDLE, START, WAIT, WAIT, RESP. Maximum is TIMEOUT+3.
- Requester rules:
  - Hold req and req_x until done.
  - A req dropped before it is granted is simply not served; nothing is queued.
  - A req dropped after the grant does not cancel the lookup; done still pulses.
  - req_x changes after the grant are ignored, because X is latched.
- Fairness: the served channel gets lowest priority next time. With all channels continuously requesting, the grant order is 0,1,2,3,0,...
- No new grant is made in RESP. A channel that re-asserts req in the cycle after its done competes normally in IDLE.
- Widths: gidx is clog2(NREQ) bits. The timer is clog2(TIMEOUT)+1 bits and saturates, with no wrap. resp_y is sign-preserving, passed through unchanged.

Decomposition:
- Package calib_sched_pkg holds:
  - the state enum (IDLE, START, WAIT, RESP)
  - POS_INVALID = 5'h1F
  - the index-width function
- One sub-module, rr_arbiter:
  - combinational: takes req and rr_ptr, produces a one-hot grant and the granted index plus a valid flag.
  - rr_ptr itself stays in calib_scheduler.

Test Plan:
- Single request: req=4'b0010, req_x[1]=16'sd1200, engine answers ready on the 2nd WAIT cycle with y=16'sd345, pos=5'd6. Expect eng_start for 1 cycle, eng_x=1200, done=4'b0010 exactly 5 cycles after req, resp_y=345, resp_pos=6, resp_timeout=0.
- Round-robin: req=4'b1111 held with each channel's X distinct. Expect grant order 0,1,2,3,0, each done one-hot, and eng_x matching each channel's X.
- Timeout: req=4'b0001 with eng_ready held 0. Expect done=4'b0001 at cycle TIMEOUT+3 (35 for TIMEOUT=32), resp_timeout=1, resp_pos=5'h1F, resp_y=0.
- Stale ready: eng_ready=1 during START and the first WAIT cycle, then 0 for 3 cycles, then 1. Expect the result captured only on the later ready, with no early done.
- Reset mid-WAIT: assert reset for 1 cycle during WAIT. Expect no done pulse, busy=0 the next cycle, and rr_ptr=0 so a subsequent req=4'b1000 is still served.
- Drop and re-request: req[2] dropped after grant, and req_x[2] changed after grant. Expect done[2] still pulses and eng_x keeps the latched value. With req[0] pending and rr_ptr at 1, a later req=4'b0101 is granted channel 2 first.
